mole_round_controller: RTL

- Game-sequencing FSM for whack-a-mole; sits between the debounced button inputs and the difficulty timer.
- Starts a game, picks a pseudo-random mole, pulses the timer start, and scores a hit or a timeout.
- Spaces rounds with a blank gap, and ends the game on a round limit or a miss limit.
- Drives the timer's enable/start/level inputs and consumes its timeout_pulse/active outputs.

---
 rtl/mole_round_controller_if.sv | 31 +++
 rtl/mole_round_controller.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mole_round_controller_if.sv
// Signal bundle between the whack-a-mole round controller, the button front end and the difficulty timer.
// The slave modport is the controller's view; master is the driver (buttons + timer) side.
interface mole_round_controller_if #(
    parameter int NUM_MOLES = 8
);
    logic                 start_game;
    logic [NUM_MOLES-1:0] btn_hit;
    logic [1:0]           level_in;
    logic                 timeout_pulse;
    logic                 timer_active;
    logic                 timer_enable;
    logic                 timer_start;
    logic [1:0]           level_out;
    logic [NUM_MOLES-1:0] mole_onehot;
    logic [7:0]           score;
    logic [7:0]           misses;
    logic [7:0]           round_cnt;
    logic                 game_over;

    modport master (
        output start_game, btn_hit, level_in, timeout_pulse, timer_active,
        input  timer_enable, timer_start, level_out, mole_onehot,
               score, misses, round_cnt, game_over
    );

    modport slave (
        input  start_game, btn_hit, level_in, timeout_pulse, timer_active,
        output timer_enable, timer_start, level_out, mole_onehot,
               score, misses, round_cnt, game_over
    );
endinterface

// File: rtl/mole_round_controller.sv
// Whack-a-mole round sequencer: spawns a pseudo-random mole, scores hit/timeout, spaces rounds, ends the game.
// Optional macro LEVEL_RAMP_EN: raise level_out by one (max 2) after every RAMP_HITS consecutive hits.
module mole_round_controller #(
    parameter int         NUM_MOLES  = 8,
    parameter int         NUM_ROUNDS = 20,
    parameter int         MAX_MISSES = 5,
    parameter int         GAP_TICKS  = 2,
    parameter logic [7:0] LFSR_SEED  = 8'hA5,
    parameter int         RAMP_HITS  = 5
) (
    input  logic                   clk_game,
    input  logic                   rst,
    mole_round_controller_if.slave bus
);
    localparam int         IDX_W     = (NUM_MOLES > 1) ? $clog2(NUM_MOLES) : 1;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SPAWN = 3'd1,
        S_LIGHT = 3'd2,
        S_WAIT  = 3'd3,
        S_GAP   = 3'd4,
        S_OVER  = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [7:0]           r_lfsr;
    logic [7:0]           w_lfsr_next;
    logic [IDX_W-1:0]     r_prev_idx, w_prev_idx_next;
    logic [IDX_W-1:0]     r_idx, w_idx_next;
    logic [15:0]          r_gap_cnt, w_gap_cnt_next;
    logic                 r_timer_enable, w_timer_enable_next;
    logic                 r_timer_start, w_timer_start_next;
    logic [1:0]           r_level, w_level_next;
    logic [NUM_MOLES-1:0] r_mole, w_mole_next;
    logic [7:0]           r_score, w_score_next;
    logic [7:0]           r_misses, w_misses_next;
    logic [7:0]           r_round, w_round_next;
    logic                 r_game_over, w_game_over_next;
`ifdef LEVEL_RAMP_EN
    logic [7:0]           r_streak, w_streak_next;
`endif

    logic                 w_hit;
    logic                 w_gap_done;
    logic                 w_end_game;
    logic [IDX_W-1:0]     w_cand;
    logic [IDX_W-1:0]     w_sel;
    logic [NUM_MOLES-1:0] w_decode;
    logic [1:0]           w_level_sel;
    logic                 w_unused;

    // Galois LFSR x^8+x^6+x^5+x^4+1, right-shifting; feedback bit is the old LSB.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lfsr
            if (gi == 7) begin : g_msb
                assign w_lfsr_next[gi] = r_lfsr[0];
            end else begin : g_bit
                assign w_lfsr_next[gi] = r_lfsr[gi+1] ^ (LFSR_TAPS[gi] & r_lfsr[0]);
            end
        end
        for (gi = 0; gi < NUM_MOLES; gi++) begin : g_dec
            assign w_decode[gi] = (r_idx == IDX_W'(gi));
        end
    endgenerate

    assign w_cand      = r_lfsr[IDX_W-1:0];
    assign w_sel       = (w_cand == r_prev_idx) ? w_cand + IDX_W'(1) : w_cand;
    assign w_hit       = |(bus.btn_hit & w_decode);
    assign w_gap_done  = (r_gap_cnt == 16'(GAP_TICKS - 1));
    assign w_end_game  = (r_misses == 8'(MAX_MISSES)) || (r_round == 8'(NUM_ROUNDS));
    assign w_level_sel = (bus.level_in == 2'd3) ? 2'd2 : bus.level_in;
    // timer_active is status only and never steers the sequence.
    assign w_unused    = bus.timer_active ^ (RAMP_HITS == 0);

    always_ff @(posedge clk_game) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE, S_OVER: if (bus.start_game) w_state_next = S_SPAWN;
            S_SPAWN:        w_state_next = S_LIGHT;
            S_LIGHT:        w_state_next = S_WAIT;
            S_WAIT:         if (w_hit || bus.timeout_pulse) w_state_next = S_GAP;
            S_GAP:          if (w_gap_done) w_state_next = w_end_game ? S_OVER : S_SPAWN;
            default:        w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_prev_idx_next     = r_prev_idx;
        w_idx_next          = r_idx;
        w_gap_cnt_next      = r_gap_cnt;
        w_timer_enable_next = r_timer_enable;
        w_timer_start_next  = 1'b0;
        w_level_next        = r_level;
        w_mole_next         = r_mole;
        w_score_next        = r_score;
        w_misses_next       = r_misses;
        w_round_next        = r_round;
        w_game_over_next    = r_game_over;
`ifdef LEVEL_RAMP_EN
        w_streak_next       = r_streak;
`endif
        unique case (r_state)
            S_IDLE, S_OVER: begin
                if (bus.start_game) begin
                    w_score_next     = 8'd0;
                    w_misses_next    = 8'd0;
                    w_round_next     = 8'd0;
                    w_level_next     = w_level_sel;
                    w_game_over_next = 1'b0;
`ifdef LEVEL_RAMP_EN
                    w_streak_next    = 8'd0;
`endif
                end
            end
            S_SPAWN: begin
                w_idx_next      = w_sel;
                w_prev_idx_next = w_sel;
                w_round_next    = r_round + 8'd1;
            end
            S_LIGHT: begin
                w_mole_next         = w_decode;
                w_timer_start_next  = 1'b1;
                w_timer_enable_next = 1'b1;
            end
            S_WAIT: begin
                // A hit outranks a simultaneous timeout.
                if (w_hit) begin
                    w_score_next        = (r_score == 8'hFF) ? r_score : r_score + 8'd1;
                    w_mole_next         = '0;
                    w_timer_enable_next = 1'b0;
                    w_gap_cnt_next      = 16'd0;
`ifdef LEVEL_RAMP_EN
                    if (r_streak + 8'd1 == 8'(RAMP_HITS)) begin
                        w_streak_next = 8'd0;
                        if (r_level != 2'd2) w_level_next = r_level + 2'd1;
                    end else begin
                        w_streak_next = r_streak + 8'd1;
                    end
`endif
                end else if (bus.timeout_pulse) begin
                    w_misses_next       = (r_misses == 8'hFF) ? r_misses : r_misses + 8'd1;
                    w_mole_next         = '0;
                    w_timer_enable_next = 1'b0;
                    w_gap_cnt_next      = 16'd0;
`ifdef LEVEL_RAMP_EN
                    w_streak_next       = 8'd0;
`endif
                end
            end
            S_GAP: begin
                w_gap_cnt_next = r_gap_cnt + 16'd1;
                if (w_gap_done && w_end_game) w_game_over_next = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_game) begin
        if (rst) begin
            r_lfsr         <= LFSR_SEED;
            r_prev_idx     <= '0;
            r_idx          <= '0;
            r_gap_cnt      <= 16'd0;
            r_timer_enable <= 1'b0;
            r_timer_start  <= 1'b0;
            r_level        <= 2'd0;
            r_mole         <= '0;
            r_score        <= 8'd0;
            r_misses       <= 8'd0;
            r_round        <= 8'd0;
            r_game_over    <= 1'b0;
`ifdef LEVEL_RAMP_EN
            r_streak       <= 8'd0;
`endif
        end else begin
            r_lfsr         <= w_lfsr_next;
            r_prev_idx     <= w_prev_idx_next;
            r_idx          <= w_idx_next;
            r_gap_cnt      <= w_gap_cnt_next;
            r_timer_enable <= w_timer_enable_next;
            r_timer_start  <= w_timer_start_next;
            r_level        <= w_level_next;
            r_mole         <= w_mole_next;
            r_score        <= w_score_next;
            r_misses       <= w_misses_next;
            r_round        <= w_round_next;
            r_game_over    <= w_game_over_next;
`ifdef LEVEL_RAMP_EN
            r_streak       <= w_streak_next;
`endif
        end
    end

    assign bus.timer_enable = r_timer_enable;
    assign bus.timer_start  = r_timer_start;
    assign bus.level_out    = r_level;
    assign bus.mole_onehot  = r_mole;
    assign bus.score        = r_score;
    assign bus.misses       = r_misses;
    assign bus.round_cnt    = r_round;
    assign bus.game_over    = r_game_over;
endmodule
